// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared types and constants for the CPU-to-SRAM/IO bridge
package mem_io_pkg;

  typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

  localparam int IO_IDX_W = 4;
  localparam logic [IO_IDX_W-1:0] IO_IDX_SW = 4'hF;

  // The all-ones word address always reaches the switch port, whatever the page.
  function automatic logic is_io_hit(input logic [15:0] addr, input logic [11:0] page);
    return (addr[15:4] == page) || (addr == 16'hFFFF);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for asynchronous board inputs
module sync2 #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU-to-SRAM/IO bridge with wait states, byte enables and an IO page
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 20,
  parameter logic [11:0] IO_PAGE     = 12'hFFF,
  parameter int          NUM_HEX     = 2,
  parameter int          WAIT_STATES = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [DATA_W/8-1:0]       cpu_be,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_ce_n,
  output logic                      mem_oe_n,
  output logic                      mem_we_n,
  output logic [DATA_W/8-1:0]       mem_be_n,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wdata_oe,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic [DATA_W-1:0]         switches,
  output logic [NUM_HEX*DATA_W-1:0] hex_out
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q;
  logic                      we_q;
  logic [BE_W-1:0]           be_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic [NUM_HEX*DATA_W-1:0] hex_q, hex_d;
  logic [DATA_W-1:0]         sw_sync;
  logic [DATA_W-1:0]         io_rdata;
  logic [IO_IDX_W-1:0]       idx_q;
  logic                      accept;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (switches),
    .q_o   (sw_sync)
  );

  assign accept = (state_q == IDLE) && cpu_req;
  assign idx_q  = addr_q[IO_IDX_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cpu_req) state_d = is_io_hit(cpu_addr[15:0], IO_PAGE) ? IO : MEM;
      MEM:  if (wait_cnt_q == 4'd0) state_d = DONE;
      IO:   state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ce_n     = 1'b1;
    mem_oe_n     = 1'b1;
    mem_we_n     = 1'b1;
    mem_be_n     = '1;
    mem_wdata_oe = 1'b0;
    cpu_ready    = 1'b0;
    case (state_q)
      MEM: begin
        mem_ce_n = 1'b0;
        mem_be_n = ~be_q;
        if (we_q) begin
          mem_we_n     = 1'b0;
          mem_wdata_oe = 1'b1;
        end else begin
          mem_oe_n = 1'b0;
        end
      end
      DONE:    cpu_ready = 1'b1;
      default: ;
    endcase
  end

  // IO register file read mux and byte-lane write merge.
  always_comb begin
    io_rdata = '0;
    hex_d    = hex_q;
    for (int i = 0; i < NUM_HEX; i++) begin
      if (idx_q == IO_IDX_W'(i)) begin
        io_rdata = hex_q[i*DATA_W +: DATA_W];
        if (state_q == IO && we_q) begin
          for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) hex_d[i*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
    end
    if (idx_q == IO_IDX_SW) io_rdata = sw_sync;
  end

  always_comb begin
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    if (accept) wait_cnt_d = WAIT_INIT;
    if (state_q == MEM) begin
      if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
      else if (!we_q)         rdata_d    = mem_rdata;
    end
    if (state_q == IO && !we_q) rdata_d = io_rdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      hex_q      <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        be_q    <= cpu_be;
        wdata_q <= cpu_wdata;
      end
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      hex_q      <= hex_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign hex_out   = hex_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - randomized self-checking bench for mem_io_bridge
module tb_mem_io_bridge;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int NH = 2;
  localparam int WS = 2;
  localparam int BW = DW / 8;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            cpu_req, cpu_we;
  logic [BW-1:0]   cpu_be;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata, cpu_rdata;
  logic            cpu_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_ce_n, mem_oe_n, mem_we_n;
  logic [BW-1:0]   mem_be_n;
  logic [DW-1:0]   mem_wdata, mem_rdata, switches;
  logic            mem_wdata_oe;
  logic [NH*DW-1:0] hex_out;

  always #5 Clk = ~Clk;

  mem_io_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .IO_PAGE(12'hFFF), .NUM_HEX(NH), .WAIT_STATES(WS)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_be_n(mem_be_n), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .switches(switches), .hex_out(hex_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Board SRAM seen through the pins; unwritten words hold an address-derived pattern.
  logic [DW-1:0] sram [logic [AW-1:0]];

  function automatic logic [DW-1:0] fresh(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] ^ a[7:0] ^ 8'h3C};
  endfunction

  always @(negedge Clk) begin
    logic [DW-1:0] w;
    w = sram.exists(mem_addr) ? sram[mem_addr] : fresh(mem_addr);
    mem_rdata = (!mem_ce_n && !mem_oe_n) ? w : 16'hDEAD;
    if (!mem_ce_n && !mem_we_n) begin
      for (int b = 0; b < BW; b++) if (!mem_be_n[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      sram[mem_addr] = w;
    end
  end

  // Transaction-level reference state.
  logic [DW-1:0]    ref_mem [logic [AW-1:0]];
  logic [NH*DW-1:0] ref_hex;
  logic [DW-1:0]    ref_rdata;

  task automatic access(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input string tag);
    int cyc, ce_c, oe_c, we_c, en_c, exp_lat;
    bit pin_bad, got_rdy;
    logic is_io;
    int idx;
    logic [DW-1:0] exp_rd, w;
    logic [31:0] exp_cnt;

    is_io  = (addr[15:4] == 12'hFFF) || (addr[15:0] == 16'hFFFF);
    idx    = int'(addr[3:0]);
    exp_rd = ref_rdata;
    if (is_io) begin
      exp_lat = 2;
      exp_cnt = 32'h0;
      if (we) begin
        if (idx < NH)
          for (int b = 0; b < BW; b++) if (be[b]) ref_hex[idx*DW + b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        exp_rd = (idx < NH) ? ref_hex[idx*DW +: DW] : (idx == 15 ? switches : '0);
      end
    end else begin
      exp_lat = WS + 2;
      w = ref_mem.exists(addr) ? ref_mem[addr] : fresh(addr);
      if (we) begin
        for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        ref_mem[addr] = w;
        exp_cnt = {8'(WS + 1), 8'd0, 8'(WS + 1), 8'(WS + 1)};
      end else begin
        exp_rd  = w;
        exp_cnt = {8'(WS + 1), 8'(WS + 1), 8'd0, 8'd0};
      end
    end

    @(negedge Clk);
    check({tag, "/rdy_idle"}, 64'(cpu_ready), 64'd0);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    @(posedge Clk);
    cyc = 0; ce_c = 0; oe_c = 0; we_c = 0; en_c = 0; pin_bad = 0; got_rdy = 0;
    while (cyc < 40 && !got_rdy) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        cpu_req = 1'b0; cpu_we = $urandom_range(0, 1); cpu_be = BW'($urandom);
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end
      if (!mem_ce_n) ce_c++;
      if (!mem_oe_n) oe_c++;
      if (!mem_we_n) we_c++;
      if (mem_wdata_oe) en_c++;
      if (!mem_ce_n && (mem_addr !== addr || mem_be_n !== ~be || (we && mem_wdata !== wd)))
        pin_bad = 1;
      if (cpu_ready) got_rdy = 1;
    end
    check({tag, "/latency"}, got_rdy ? 64'(cyc) : 64'hFFFF, 64'(exp_lat));
    check({tag, "/rdata"}, 64'(cpu_rdata), 64'(exp_rd));
    check({tag, "/strobe_cnt"}, 64'({8'(ce_c), 8'(oe_c), 8'(we_c), 8'(en_c)}), 64'(exp_cnt));
    check({tag, "/pins"}, 64'(pin_bad), 64'd0);
    check({tag, "/hex"}, 64'(hex_out), 64'(ref_hex));
    ref_rdata = exp_rd;
  endtask

  initial begin
    logic [5:0] rdy_pat;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic we;
    int k;

    Reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    switches = '0; ref_hex = '0; ref_rdata = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("reset_pins", 64'({mem_ce_n, mem_oe_n, mem_we_n, mem_be_n, mem_wdata_oe, cpu_ready}),
            64'(7'b1111100));
    end
    check("reset_rdata", 64'(cpu_rdata), 64'd0);
    check("reset_hex", 64'(hex_out), 64'd0);
    check("reset_maddr", 64'(mem_addr), 64'd0);

    access(1'b1, 2'b11, 20'h0FFF0, 16'h1234, "io_wr0");
    check("io_wr0_val", 64'(hex_out[15:0]), 64'h1234);
    access(1'b1, 2'b01, 20'h0FFF1, 16'hABCD, "io_wr1_be");
    access(1'b0, 2'b11, 20'h0FFF1, 16'h0000, "io_rd1");
    check("io_rd1_val", 64'(cpu_rdata), 64'h00CD);

    switches = 16'h5A5A;
    repeat (3) @(negedge Clk);
    access(1'b0, 2'b11, 20'h0FFFF, 16'h0000, "sw_rd");
    check("sw_rd_val", 64'(cpu_rdata), 64'h5A5A);

    sram[20'h00010] = 16'hBEEF;
    ref_mem[20'h00010] = 16'hBEEF;
    access(1'b0, 2'b11, 20'h00010, 16'h0000, "mem_rd");
    check("mem_rd_val", 64'(cpu_rdata), 64'hBEEF);
    access(1'b1, 2'b11, 20'h00010, 16'hC0DE, "mem_wr");
    access(1'b0, 2'b11, 20'h00010, 16'h0000, "mem_rdback");
    check("mem_rdback_val", 64'(cpu_rdata), 64'hC0DE);

    // Abort a read in its second SRAM cycle.
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 20'h00020;
    @(posedge Clk);
    @(negedge Clk);
    cpu_req = 1'b0;
    @(negedge Clk);
    check("abort_in_mem", 64'(mem_ce_n), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    ref_hex = '0; ref_rdata = '0;
    check("abort_pins", 64'({mem_ce_n, mem_oe_n, mem_we_n, mem_be_n, mem_wdata_oe, cpu_ready}),
          64'(7'b1111100));
    check("abort_hex", 64'(hex_out), 64'd0);
    rdy_pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      rdy_pat[i] = cpu_ready;
    end
    check("abort_no_ready", 64'(rdy_pat), 64'd0);

    // req held across two IO accesses: ready, idle gap, ready.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 20'h0FFF0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      rdy_pat[i] = cpu_ready;
      if (i == 4) cpu_req = 1'b0;
    end
    check("held_req_ready", 64'(rdy_pat), 64'(6'b010010));
    check("held_req_rdata", 64'(cpu_rdata), 64'd0);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        switches = DW'($urandom);
        repeat (3) @(negedge Clk);
      end
      k  = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      be = BW'($urandom);
      wd = DW'($urandom);
      case (k)
        0:       a = {4'($urandom), 12'hFFF, 4'($urandom_range(0, NH - 1))};
        1:       a = {4'($urandom), 16'hFFFF};
        2:       a = {4'($urandom), 12'hFFF, 4'($urandom_range(NH, 14))};
        default: a = {4'($urandom), 8'h00, 4'($urandom_range(0, 3)), 4'($urandom)};
      endcase
      access(we, be, a, wd, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
